// File: rtl/instruction_fetch_queue_pkg.sv
// Shared widths and the queue entry type for the instruction fetch stage.
package instruction_fetch_queue_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Control, memory request/response and decode handshake signals of the fetch stage.
interface instruction_fetch_queue_if;
    import instruction_fetch_queue_pkg::*;

    logic            enable;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [ILEN-1:0] mem_rsp_data;
    logic            valid;
    logic            ready;
    logic [ILEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;

    // master: the surroundings (core control, memory, decode); slave: the fetch stage
    modport master (
        output enable, redirect, redirect_pc, mem_req_ready, mem_rsp_valid,
               mem_rsp_data, ready,
        input  mem_req_valid, mem_req_addr, valid, instruction, pc, pc_next
    );

    modport slave (
        input  enable, redirect, redirect_pc, mem_req_ready, mem_rsp_valid,
               mem_rsp_data, ready,
        output mem_req_valid, mem_req_addr, valid, instruction, pc, pc_next
    );

endinterface

// File: rtl/instruction_fetch_queue_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; head read straight from storage.
module instruction_fetch_queue_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_ptr];

    // Storage is reset so the head reads {RESET_PC, 0} out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '{pc: RESET_PC, instr: '0};
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop_ok && !flush));

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: credit-limited sequential PC requests, in-order response queueing,
// redirect with flush and discard of responses to requests issued before the redirect.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_queue_if.slave   bus
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [CW:0]     in_flight;
    logic            full;
    logic            empty;
    logic            req_valid;
    logic            fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // Credit covers words already queued plus words still owed by memory.
    assign in_flight  = {1'b0, outstanding} + {1'b0, count};
    assign req_valid  = !rst && bus.enable && !bus.redirect
                        && (in_flight < (CW+1)'(DEPTH));
    assign fire       = req_valid && bus.mem_req_ready;
    assign rsp_drop   = bus.mem_rsp_valid && (drop_cnt != '0);
    assign push       = bus.mem_rsp_valid && !rsp_drop && !bus.redirect;
    assign pop        = !empty && bus.ready && !bus.redirect;
    assign target_pc  = word_align(bus.redirect_pc);
    assign push_entry = '{pc: rsp_pc, instr: bus.mem_rsp_data};

    instruction_fetch_queue_fifo #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (bus.redirect),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (bus.redirect) begin
            // Everything still owed by memory belongs to the old path.
            fetch_pc    <= target_pc;
            rsp_pc      <= target_pc;
            outstanding <= outstanding - CW'(bus.mem_rsp_valid);
            drop_cnt    <= outstanding - CW'(bus.mem_rsp_valid);
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (push) begin
                rsp_pc <= rsp_pc + PC_STEP;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            outstanding <= outstanding + CW'(fire) - CW'(bus.mem_rsp_valid);
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.valid         = !empty;
    assign bus.instruction   = head.instr;
    assign bus.pc            = head.pc;
    assign bus.pc_next       = head.pc + PC_STEP;

    credit_bound: assert property (@(posedge clk) disable iff (rst)
        in_flight <= (CW+1)'(DEPTH));

    push_room: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop));

endmodule
